// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of an asynchronous SRAM.
// Each granted transaction runs IDLE -> SETUP -> ACCESS (WAIT_STATES cycles)
// -> DONE, with every output except the tristate data bus registered.
//
// Ports:
//   Clk, Reset             clock, synchronous active-low reset
//   Req/We/Addr/WData0..1  port requests (held high until Ack), direction,
//                          word address, write data
//   Ack0..1, RData0..1     one-cycle completion pulse, last read data
//   SRAM_ADDR, SRAM_Data   SRAM address and bidirectional data bus
//   CE, UB, LB, OE, WE     SRAM strobes, active-low
//   Busy                   high whenever a transaction is in progress
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req0,
    input  logic        We0,
    input  logic [15:0] Addr0,
    input  logic [15:0] WData0,
    output logic        Ack0,
    output logic [15:0] RData0,
    input  logic        Req1,
    input  logic        We1,
    input  logic [15:0] Addr1,
    input  logic [15:0] WData1,
    output logic        Ack1,
    output logic [15:0] RData1,
    output logic [15:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_Data,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic        Busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    // Last granted port; also identifies the owner of the current transaction.
    logic        grant_q, grant_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        drive_q;

    logic        ce_d, oe_d, we_n_d, drive_d, ack0_d, ack1_d, busy_d;
    logic [15:0] sram_addr_d;
    logic        last_access, cap0, cap1;

    assign SRAM_Data = drive_q ? wdata_q : 16'hzzzz;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    grant_d = (Req0 && Req1) ? ~grant_q : Req1;
                    wr_d    = grant_d ? We1    : We0;
                    addr_d  = grant_d ? Addr1  : Addr0;
                    wdata_d = grant_d ? WData1 : WData0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = 4'(WAIT_STATES - 1);
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        last_access = (state_q == ACCESS) && (cnt_q == '0);
        cap0        = last_access && !wr_q && !grant_q;
        cap1        = last_access && !wr_q &&  grant_q;

        // Strobes are registered, so they are derived from the state being entered.
        ce_d        = 1'b1;
        oe_d        = 1'b1;
        we_n_d      = 1'b1;
        drive_d     = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        sram_addr_d = SRAM_ADDR;
        case (state_d)
            SETUP: begin
                ce_d        = 1'b0;
                oe_d        = wr_d;
                drive_d     = wr_d;
                sram_addr_d = addr_d;
            end
            ACCESS: begin
                ce_d    = 1'b0;
                oe_d    = wr_d;
                we_n_d  = ~wr_d;
                drive_d = wr_d;
            end
            DONE: begin
                ack0_d = ~grant_d;
                ack1_d = grant_d;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= 1'b1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            drive_q   <= 1'b0;
            CE        <= 1'b1;
            UB        <= 1'b1;
            LB        <= 1'b1;
            OE        <= 1'b1;
            WE        <= 1'b1;
            Ack0      <= 1'b0;
            Ack1      <= 1'b0;
            RData0    <= '0;
            RData1    <= '0;
            SRAM_ADDR <= '0;
            Busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            drive_q   <= drive_d;
            CE        <= ce_d;
            UB        <= ce_d;
            LB        <= ce_d;
            OE        <= oe_d;
            WE        <= we_n_d;
            Ack0      <= ack0_d;
            Ack1      <= ack1_d;
            SRAM_ADDR <= sram_addr_d;
            Busy      <= busy_d;
            if (cap0) RData0 <= SRAM_Data;
            if (cap1) RData1 <= SRAM_Data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with an SRAM model,
// a transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, and a randomized request phase.
module tb_mem_arbiter;

    localparam int WS = 2;

    logic        Clk, Reset;
    logic        Req0, We0, Req1, We1;
    logic [15:0] Addr0, WData0, Addr1, WData1;
    logic        Ack0, Ack1;
    logic [15:0] RData0, RData1, SRAM_ADDR;
    logic        CE, UB, LB, OE, WE, Busy;
    tri1  [15:0] sram_data;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0), .Ack0(Ack0), .RData0(RData0),
        .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1), .Ack1(Ack1), .RData1(RData1),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_Data(sram_data),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- SRAM model ----------------
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : ((a ^ 16'hC3A5) + 16'h0101);
    endfunction

    logic [15:0] sram_mem [65536];
    bit          sram_vld [65536];
    logic [15:0] mem_rd;
    logic        rd_en;

    assign rd_en     = !CE && !OE && WE;
    assign mem_rd    = sram_vld[SRAM_ADDR] ? sram_mem[SRAM_ADDR] : init_val(SRAM_ADDR);
    assign sram_data = rd_en ? mem_rd : 16'hzzzz;

    always @(posedge Clk) begin
        if (!CE && !WE) begin
            sram_mem[SRAM_ADDR] <= sram_data;
            sram_vld[SRAM_ADDR] <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    // k_m counts edges since the grant: 0 = setup, 1..WS = access, WS+1 = done.
    bit          act_m  = 0;
    int          k_m    = 0;
    bit          last_m = 1;
    bit          g_m    = 0;
    bit          we_m   = 0;
    logic [15:0] addr_m = '0, wd_m = '0, sa_m = '0;
    logic [15:0] rd_m [2];
    logic [15:0] ref_mem [65536];
    bit          ref_vld [65536];

    always @(posedge Clk) begin
        if (!Reset) begin
            act_m = 0; k_m = 0; last_m = 1; sa_m = '0;
            rd_m[0] = '0; rd_m[1] = '0;
        end else if (!act_m) begin
            if (Req0 || Req1) begin
                g_m    = (Req0 && Req1) ? !last_m : Req1;
                last_m = g_m;
                we_m   = g_m ? We1 : We0;
                addr_m = g_m ? Addr1 : Addr0;
                wd_m   = g_m ? WData1 : WData0;
                sa_m   = addr_m;
                act_m  = 1; k_m = 0;
            end
        end else begin
            k_m++;
            if (k_m == WS + 1) begin
                if (we_m) begin
                    ref_mem[addr_m] = wd_m;
                    ref_vld[addr_m] = 1;
                end else begin
                    rd_m[g_m] = ref_vld[addr_m] ? ref_mem[addr_m] : init_val(addr_m);
                end
            end else if (k_m == WS + 2) begin
                act_m = 0;
            end
        end
    end

    always @(negedge Clk) begin
        bit in_sa, in_acc, in_done;
        in_sa   = act_m && (k_m <= WS);
        in_acc  = act_m && (k_m >= 1) && (k_m <= WS);
        in_done = act_m && (k_m == WS + 1);
        chk("busy",   Busy, act_m);
        chk("ce",     CE, !in_sa);
        chk("ub",     UB, !in_sa);
        chk("lb",     LB, !in_sa);
        chk("oe",     OE, !(in_sa && !we_m));
        chk("we",     WE, !(in_acc && we_m));
        chk("ack0",   Ack0, in_done && !g_m);
        chk("ack1",   Ack1, in_done && g_m);
        chk("rdata0", RData0, rd_m[0]);
        chk("rdata1", RData1, rd_m[1]);
        chk("addr",   SRAM_ADDR, sa_m);
        chk("oe_we_excl", !(!OE && !WE), 1'b1);
        if (CE) chk("ce_idle_strobes", {UB, LB, OE, WE}, 4'hF);
        if (in_sa && we_m)       chk("bus_wdata", sram_data, wd_m);
        else if (!(in_sa && !we_m)) chk("bus_z", sram_data, 16'hFFFF);
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        Reset = 1'b0;
        Req0 = 0; Req1 = 0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b1;
    endtask

    task automatic xact(input bit p, input bit w, input logic [15:0] a, input logic [15:0] d,
                        output int n, output int oe_lo, output int we_lo,
                        output logic [15:0] bus1, output logic [15:0] bus_done);
        n = 0; oe_lo = 0; we_lo = 0; bus1 = '0; bus_done = '0;
        if (p) begin Req1 = 1; We1 = w; Addr1 = a; WData1 = d; end
        else   begin Req0 = 1; We0 = w; Addr0 = a; WData0 = d; end
        while (n < 40) begin
            @(posedge Clk); #1;
            n++;
            if (!OE) oe_lo++;
            if (!WE) we_lo++;
            if (n == 1) bus1 = sram_data;
            if (p ? Ack1 : Ack0) begin
                bus_done = sram_data;
                break;
            end
        end
        Req0 = 0; Req1 = 0;
    endtask

    initial begin
        int n, oe_lo, we_lo, ord_n, cyc, t0, t1;
        logic [15:0] b1, bd;
        bit ord [4];
        bit ack_seen;

        Req0 = 0; We0 = 0; Addr0 = '0; WData0 = '0;
        Req1 = 0; We1 = 0; Addr1 = '0; WData1 = '0;
        do_reset();
        @(negedge Clk);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_strobes", {CE, UB, LB, OE, WE}, 5'h1F);
        chk("rst_rdata0", RData0, 16'h0000);
        chk("rst_addr", SRAM_ADDR, 16'h0000);
        chk("rst_bus_z", sram_data, 16'hFFFF);

        // Single read
        @(posedge Clk); #1;
        xact(0, 0, 16'h0010, 16'h0000, n, oe_lo, we_lo, b1, bd);
        chk("rd_latency", 16'(n), 16'(WS + 2));
        chk("rd_oe_cycles", 16'(oe_lo), 16'd3);
        chk("rd_we_cycles", 16'(we_lo), 16'd0);
        chk("rd_rdata0", RData0, 16'hBEEF);

        // Single write on port 1
        @(posedge Clk); #1;
        xact(1, 1, 16'h1234, 16'hA5A5, n, oe_lo, we_lo, b1, bd);
        chk("wr_latency", 16'(n), 16'(WS + 2));
        chk("wr_we_cycles", 16'(we_lo), 16'd2);
        chk("wr_bus_setup", b1, 16'hA5A5);
        chk("wr_bus_done_z", bd, 16'hFFFF);
        chk("wr_rdata1", RData1, 16'h0000);
        chk("wr_sram", sram_mem[16'h1234], 16'hA5A5);

        // Read back the written word
        @(posedge Clk); #1;
        xact(0, 0, 16'h1234, 16'h0000, n, oe_lo, we_lo, b1, bd);
        chk("rdback_rdata0", RData0, 16'hA5A5);
        chk("rdback_rdata1", RData1, 16'h0000);

        // Contention from reset: grants alternate starting with port 0
        Reset = 0; Req0 = 1; Req1 = 1; We0 = 0; We1 = 0; Addr0 = 16'h0005; Addr1 = 16'h0006;
        repeat (2) @(posedge Clk);
        #1 Reset = 1;
        ord_n = 0;
        for (int i = 0; i < 60 && ord_n < 4; i++) begin
            @(posedge Clk); #1;
            if (Ack0 && Ack1) chk("both_ack", 16'd1, 16'd0);
            if (Ack0) begin ord[ord_n] = 0; ord_n++; end
            else if (Ack1) begin ord[ord_n] = 1; ord_n++; end
        end
        Req0 = 0; Req1 = 0;
        chk("cont_count", 16'(ord_n), 16'd4);
        for (int i = 0; i < 4; i++) chk("cont_order", 16'(ord[i]), 16'(i % 2));

        // Back-to-back on port 0
        do_reset();
        Req0 = 1; We0 = 0; Addr0 = 16'h0003;
        t0 = -1; t1 = -1; cyc = 0;
        while (cyc < 60 && t1 < 0) begin
            @(posedge Clk); #1;
            cyc++;
            if (Ack0) begin
                if (t0 < 0) t0 = cyc; else t1 = cyc;
            end
        end
        Req0 = 0;
        chk("b2b_spacing", 16'(t1 - t0), 16'(WS + 3));

        // Reset at the edge ending the last ACCESS of a read
        do_reset();
        Req0 = 1; We0 = 0; Addr0 = 16'h0010;
        repeat (3) @(posedge Clk);
        #1 Reset = 0; Req0 = 0;
        @(posedge Clk); #1;
        chk("abort_strobes", {CE, UB, LB, OE, WE}, 5'h1F);
        chk("abort_ack0", Ack0, 1'b0);
        chk("abort_rdata0", RData0, 16'h0000);
        chk("abort_busy", Busy, 1'b0);
        Reset = 1;
        ack_seen = 0;
        repeat (8) begin
            @(posedge Clk); #1;
            if (Ack0 || Ack1) ack_seen = 1;
        end
        chk("abort_no_late_ack", 16'(ack_seen), 16'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge Clk); #1;
            if (Ack0)       Req0 = ($urandom_range(0, 1) == 1);
            else if (!Req0) Req0 = ($urandom_range(0, 9) < 3);
            if (Ack1)       Req1 = ($urandom_range(0, 1) == 1);
            else if (!Req1) Req1 = ($urandom_range(0, 9) < 3);
            We0 = 1'($urandom_range(0, 1)); Addr0 = 16'($urandom_range(0, 31)); WData0 = 16'($urandom);
            We1 = 1'($urandom_range(0, 1)); Addr1 = 16'($urandom_range(0, 31)); WData1 = 16'($urandom);
        end
        Req0 = 0; Req1 = 0;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
